// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage_if
// Purpose  : valid/ready payload channel into and out of a pipe_skid_stage.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_skid_stage_if #(
    parameter int unsigned DATA_W = 160
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // slave: the stage itself; master: the surrounding pipeline
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : two-entry elastic pipeline register with registered in_ready and
//            synchronous flush. Define PIPE_SKID_PERF_EN to add the saturating
//            stall_cnt / bubble_cnt performance counters (and CNT_W).
// Revision : 1.0  initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int unsigned       DATA_W     = 160,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
`ifdef PIPE_SKID_PERF_EN
    ,
    parameter int unsigned       CNT_W      = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_skid_stage_if.slave    bus,
    output logic [1:0]          occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
`endif
);

    // The state value is the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state_q,     w_state_d;
    logic [DATA_W-1:0] r_main_data_q, w_main_data_d;
    logic [DATA_W-1:0] r_skid_data_q, w_skid_data_d;
    logic              r_in_ready_q,  w_in_ready_d;

    logic w_out_valid;
    logic w_accept;
    logic w_emit;

    assign w_out_valid = (r_state_q != ST_EMPTY);
    assign w_accept    = bus.in_valid & r_in_ready_q;
    assign w_emit      = w_out_valid & bus.out_ready;

    assign bus.in_ready  = r_in_ready_q;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_data_q;
    assign occupancy     = r_state_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_main_data_d = r_main_data_q;
        w_skid_data_d = r_skid_data_q;

        if (flush) begin
            w_state_d     = ST_EMPTY;
            w_main_data_d = RESET_DATA;
            w_skid_data_d = RESET_DATA;
        end else begin
            case (r_state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_data_d = bus.in_data;
                        w_state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_emit && w_accept) begin
                        w_main_data_d = bus.in_data;
                    end else if (w_emit) begin
                        w_state_d = ST_EMPTY;
                    end else if (w_accept) begin
                        w_skid_data_d = bus.in_data;
                        w_state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so nothing can be accepted alongside the emit
                    if (w_emit) begin
                        w_main_data_d = r_skid_data_q;
                        w_state_d     = ST_ONE;
                    end
                end
                default: begin
                    w_state_d = ST_EMPTY;
                end
            endcase
        end

        // ready is a pure function of the next state, so downstream ready never reaches upstream
        w_in_ready_d = (w_state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_EMPTY;
            r_main_data_q <= RESET_DATA;
            r_skid_data_q <= RESET_DATA;
            r_in_ready_q  <= 1'b1;
        end else begin
            r_state_q     <= w_state_d;
            r_main_data_q <= w_main_data_d;
            r_skid_data_q <= w_skid_data_d;
            r_in_ready_q  <= w_in_ready_d;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt_q,  w_stall_cnt_d;
    logic [CNT_W-1:0] r_bubble_cnt_q, w_bubble_cnt_d;

    // Counters saturate and are deliberately untouched by flush.
    always_comb begin
        w_stall_cnt_d  = r_stall_cnt_q;
        w_bubble_cnt_d = r_bubble_cnt_q;
        if (w_out_valid && !bus.out_ready && !(&r_stall_cnt_q)) begin
            w_stall_cnt_d = r_stall_cnt_q + c_CNT_ONE;
        end
        if (!w_out_valid && !(&r_bubble_cnt_q)) begin
            w_bubble_cnt_d = r_bubble_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt_q  <= '0;
            r_bubble_cnt_q <= '0;
        end else begin
            r_stall_cnt_q  <= w_stall_cnt_d;
            r_bubble_cnt_q <= w_bubble_cnt_d;
        end
    end

    assign stall_cnt  = r_stall_cnt_q;
    assign bubble_cnt = r_bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : directed + randomized self-checking bench for pipe_skid_stage
//            against a queue-based model of a two-deep FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int unsigned    DW      = 160;
    localparam logic [DW-1:0]  RST_VAL = {5{32'hC0DE_5A5A}};
`ifdef PIPE_SKID_PERF_EN
    localparam int unsigned    CW      = 4;
    localparam int             CMAX    = (1 << CW) - 1;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    pipe_skid_stage_if #(.DATA_W(DW)) bus ();

    pipe_skid_stage #(
        .DATA_W     (DW),
        .RESET_DATA (RST_VAL)
`ifdef PIPE_SKID_PERF_EN
        ,
        .CNT_W      (CW)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .occupancy  (occupancy)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two payloads; ready when fewer than two are held.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_hold;
    logic [DW-1:0] m_popped;
    bit            m_live = 1'b0;
    bit            m_did_pop;
    int            m_sz;
    int            m_stall  = 0;
    int            m_bubble = 0;

    always @(negedge clk) begin
        m_sz = mq.size();
        if (m_live) begin
            chk1("out_valid", bus.out_valid, m_sz != 0);
            chk1("in_ready",  bus.in_ready,  m_sz < 2);
            chkd("out_data",  bus.out_data,  (m_sz != 0) ? mq[0] : m_hold);
            chkn("occupancy", 32'(occupancy), 32'(m_sz));
`ifdef PIPE_SKID_PERF_EN
            chkn("stall_cnt",  32'(stall_cnt),  32'(m_stall));
            chkn("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
`endif
        end

        if (rst) begin
            mq.delete();
            m_hold   = RST_VAL;
            m_live   = 1'b1;
            m_stall  = 0;
            m_bubble = 0;
        end else if (m_live) begin
`ifdef PIPE_SKID_PERF_EN
            if (m_sz > 0 && !bus.out_ready && m_stall < CMAX) m_stall++;
            if (m_sz == 0 && m_bubble < CMAX) m_bubble++;
`endif
            if (flush) begin
                mq.delete();
                m_hold = RST_VAL;
            end else begin
                m_did_pop = 1'b0;
                if (m_sz > 0 && bus.out_ready) begin
                    m_popped  = mq.pop_front();
                    m_did_pop = 1'b1;
                end
                if (bus.in_valid && m_sz < 2) mq.push_back(bus.in_data);
                if (m_did_pop && mq.size() == 0) m_hold = m_popped;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        tick();
        tick();
        chk1("rst_in_ready",  bus.in_ready, 1'b1);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chkn("rst_occupancy", 32'(occupancy), 32'd0);
        chkd("rst_out_data",  bus.out_data, RST_VAL);
        rst = 1'b0;

        // Full-throughput streaming
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(k);
            tick();
            chk1("stream_valid", bus.out_valid, 1'b1);
            chkd("stream_data",  bus.out_data, DW'(k));
            chkn("stream_occ",   32'(occupancy), 32'd1);
            chk1("stream_ready", bus.in_ready, 1'b1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk1("drain_valid", bus.out_valid, 1'b0);
        chkd("drain_hold",  bus.out_data, DW'(8));

        // Fill to FULL under backpressure, then drain in order
        bus.out_ready = 1'b0;
        send(DW'('hA));
        chkn("fill1_occ", 32'(occupancy), 32'd1);
        chk1("fill1_rdy", bus.in_ready, 1'b1);
        send(DW'('hB));
        chkn("fill2_occ", 32'(occupancy), 32'd2);
        chk1("fill2_rdy", bus.in_ready, 1'b0);
        chkd("fill2_data", bus.out_data, DW'('hA));
        bus.out_ready = 1'b1;
        tick();
        chkd("emitB_data", bus.out_data, DW'('hB));
        chk1("emitB_rdy",  bus.in_ready, 1'b1);
        tick();
        chkn("empty_occ", 32'(occupancy), 32'd0);

        // Flush while FULL with a concurrent input beat
        bus.out_ready = 1'b0;
        send(DW'('hA));
        send(DW'('hB));
        flush = 1'b1; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = DW'('hD);
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk1("flush_valid", bus.out_valid, 1'b0);
        chkn("flush_occ",   32'(occupancy), 32'd0);
        chkd("flush_data",  bus.out_data, RST_VAL);
        chk1("flush_rdy",   bus.in_ready, 1'b1);
        repeat (3) begin
            tick();
            chk1("post_flush_valid", bus.out_valid, 1'b0);
        end

        // Reset beats flush and a concurrent input
        bus.out_ready = 1'b0;
        send(DW'('hA));
        send(DW'('hB));
        rst = 1'b1; flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = DW'('hC);
        tick();
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        chkn("rst_full_occ",  32'(occupancy), 32'd0);
        chkd("rst_full_data", bus.out_data, RST_VAL);
        tick();
        chk1("rst_no_capture", bus.out_valid, 1'b0);

`ifdef PIPE_SKID_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        send(DW'('h11));
        repeat (5) tick();
        chkn("perf_stall5",  32'(stall_cnt),  32'd5);
        chkn("perf_bubble1", 32'(bubble_cnt), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        repeat (3) tick();
        chkn("perf_bubble4", 32'(bubble_cnt), 32'd4);
        bus.out_ready = 1'b0;
        send(DW'('h22));
        repeat (20) tick();
        chkn("perf_stall_sat", 32'(stall_cnt), 32'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chkn("perf_flush_keep", 32'(bubble_cnt), 32'd5);
`endif

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = (c % 1000 < 500) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            flush         = ($urandom % 97) == 0;
            rst           = ($urandom % 1999) == 0;
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chkn("final_drained", 32'(mq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, elastic successor to the fixed-field MEM/WB-style latch (fixed fields, single global enable).
- Carries an opaque DATA_W-bit payload between two pipeline stages using a valid/ready handshake.
- Two-entry skid buffer: registered in_ready, full throughput, no combinational ready path from downstream to upstream.
- Synchronous flush kills all in-flight entries. Used for every inter-stage boundary in the next core revision.

Parameters:
- DATA_W, 160, payload width in bits (wd, wreg, wdata, pc, hi/lo, cp0, except_type, mem_addr, tlb_op packed by the instantiating stage).
- RESET_DATA, 0 (DATA_W bits), value loaded into both payload registers on rst or flush.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all held entries (exception/branch redirect)
- in_valid  in  1  upstream has payload
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  main entry holds payload
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main entry payload
- occupancy  out  2  entries held, 0..2
- stall_cnt  out  CNT_W  only with PIPE_SKID_PERF_EN
- bubble_cnt  out  CNT_W  only with PIPE_SKID_PERF_EN

Behaviour:
- Storage: main (valid, data) drives out_*. Skid (valid, data) is internal.
- State encoding = occupancy: EMPTY=0, ONE=1, FULL=2.
- in_ready = (state != FULL), taken from a register.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Reset (rst=1 at clk edge): state EMPTY; out_valid=0; skid valid=0; in_ready=1; out_data = skid data = RESET_DATA; occupancy=0; counters=0.
- Transitions, evaluated only when rst=0 and flush=0:
  - EMPTY, accept → main<=in_data, ONE.
  - EMPTY, no accept → stays EMPTY.
  - ONE, emit and accept → main<=in_data, stays ONE (one transfer per cycle, zero bubbles).
  - ONE, emit only → EMPTY; main data holds its last value.
  - ONE, accept only → skid<=in_data, FULL; in_ready=0 from the next cycle.
  - ONE, neither → hold.
  - FULL, emit → main<=skid data, ONE. Input is not accepted that cycle because in_ready=0.
  - FULL, no emit → hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Order is strictly FIFO.
- Flush (rst=0, flush=1):
  - Next state EMPTY; both payloads <= RESET_DATA; in_ready=1 next cycle.
  - Any accept or emit in the flush cycle is discarded: the upstream beat is lost, and the downstream must qualify with flush.
  - rst has priority over flush.
- Simultaneous in_valid with rst or flush: ignored.
- out_data while out_valid=0 is don't-care except immediately after rst/flush, when it is RESET_DATA.
- Payload is never modified; width is exactly DATA_W.

Optional Feature:
- Macro PIPE_SKID_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0 and rst=0.
  - Both saturate at all-ones. Both clear on rst only; flush does not clear them.
- Undefined: ports stall_cnt/bubble_cnt are absent and no counter logic is synthesised.

Test Plan:
- Reset then stream 0x1..0x8 with in_valid=1 and out_ready=1 every cycle → out_valid rises 1 cycle after the first accept; outputs 0x1..0x8 on consecutive cycles; in_ready stays 1; occupancy=1.
- Send 0xA, 0xB with out_ready=0 → occupancy 1 then 2; in_ready=0 after 0xB. Raise out_ready → 0xA then 0xB emitted on consecutive cycles; in_ready=1 one cycle after 0xA leaves.
- FULL holding 0xA/0xB, pulse flush with out_ready=1 → next cycle out_valid=0, occupancy=0, out_data=RESET_DATA, in_ready=1. Neither 0xA nor 0xB is ever emitted with valid after the flush.
- Assert rst while FULL and flush=1 with in_valid=1, in_data=0xC → all outputs at reset values; 0xC is not captured.
- Random in_valid/out_ready for 10k cycles → output sequence equals input sequence; no duplicates or drops; occupancy never exceeds 2.
- With PIPE_SKID_PERF_EN: hold out_ready=0 for 5 cycles with one entry held, then 3 idle empty cycles → stall_cnt=5, bubble_cnt includes +3. With CNT_W=4, hold stalled for 20 cycles → stall_cnt saturates at 15.
